// File: rtl/cam_pkg.sv
// cam_pkg
// Shared definitions for the camera capture path:
//   - default frame geometry (IMG_W, IMG_H) and pixel count (NPIX)
//   - capture FSM state encoding
//   - bit positions of the 4-bit R/G/B fields taken from a 16-bit RGB565 word
//     laid out as {byte1, byte2} = {R[4:0], G[5:0], B[4:0]}
package cam_pkg;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int NPIX  = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    BYTE1      = 2'd1,
    BYTE2      = 2'd2
  } cap_state_t;

  // The top four bits of each RGB565 channel.
  localparam int R_MSB = 15;
  localparam int R_LSB = 12;
  localparam int G_MSB = 10;
  localparam int G_LSB = 7;
  localparam int B_MSB = 4;
  localparam int B_LSB = 1;

endpackage

// File: rtl/rgb565_to_rgb444.sv
// rgb565_to_rgb444
// Purely combinational truncation of an RGB565 word to RGB444 by keeping the
// four most significant bits of each channel. Shared with the VGA test
// pattern path.
// Ports:
//   rgb565  in  16  {R[4:0], G[5:0], B[4:0]}
//   rgb444  out 12  {R[3:0], G[3:0], B[3:0]}
module rgb565_to_rgb444
  import cam_pkg::*;
(
  input  logic [15:0] rgb565,
  output logic [11:0] rgb444
);

  // The dropped low-order channel bits are collected here so it is clear
  // they are intentionally discarded.
  logic unused_low_bits;

  assign rgb444 = {rgb565[R_MSB:R_LSB], rgb565[G_MSB:G_LSB], rgb565[B_MSB:B_LSB]};
  assign unused_low_bits = ^{rgb565[11], rgb565[6:5], rgb565[0]};

endmodule

// File: rtl/cam_capture_rgb444.sv
// cam_capture_rgb444
// Samples an OV7670-style camera bus (two RGB565 bytes per pixel), packs each
// pixel to RGB444 and drives the frame-buffer write port. Everything runs on
// the camera pixel clock; all outputs are registered.
// Ports:
//   pclk         in   1   pixel clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   vsync        in   1   high during vertical blanking / frame boundary
//   href         in   1   high while pixel bytes are valid on px_data
//   px_data      in   8   camera byte bus
//   mem_px_addr  out  AW  buffer write address
//   mem_px_data  out  DW  RGB444 pixel {R,G,B}
//   px_wr        out  1   write strobe, one pclk per pixel
//   frame_done   out  1   one-cycle pulse at frame end
//   overflow     out  1   sticky; a pixel arrived with the address at NPIX
module cam_capture_rgb444 #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = cam_pkg::IMG_W,
  parameter int IMG_H = cam_pkg::IMG_H
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);

  import cam_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);

  cap_state_t    state, state_next;
  logic          vsync_q;
  logic [7:0]    hi_byte, hi_next;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] data_next;
  logic          wr_next, done_next, ovf_next;
  logic [11:0]   pix444;

  rgb565_to_rgb444 u_pack (
    .rgb565 ({hi_byte, px_data}),
    .rgb444 (pix444)
  );

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_FRAME;
      vsync_q     <= 1'b0;
      hi_byte     <= '0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      vsync_q     <= vsync;
      hi_byte     <= hi_next;
      mem_px_addr <= addr_next;
      mem_px_data <= data_next;
      px_wr       <= wr_next;
      frame_done  <= done_next;
      overflow    <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    hi_next    = hi_byte;
    addr_next  = mem_px_addr;
    data_next  = mem_px_data;
    wr_next    = 1'b0;
    done_next  = 1'b0;
    ovf_next   = overflow;

    // The address shown during a write cycle advances on the following edge,
    // so consecutive pixels land on consecutive addresses.
    if (px_wr) begin
      addr_next = mem_px_addr + 1'b1;
    end

    unique case (state)
      WAIT_FRAME: begin
        if (vsync_q && !vsync) begin
          addr_next  = '0;
          state_next = BYTE1;
        end
      end
      BYTE1: begin
        // vsync takes priority over a byte presented in the same cycle.
        if (vsync) begin
          done_next  = 1'b1;
          state_next = WAIT_FRAME;
        end else if (href) begin
          hi_next    = px_data;
          state_next = BYTE2;
        end
      end
      BYTE2: begin
        if (vsync) begin
          done_next  = 1'b1;
          state_next = WAIT_FRAME;
        end else begin
          // href low here means the line ended mid-pixel: hi_byte is dropped.
          state_next = BYTE1;
          if (href) begin
            if (mem_px_addr == NPIX_A) begin
              ovf_next = 1'b1;
            end else begin
              wr_next   = 1'b1;
              data_next = DW'(pix444);
            end
          end
        end
      end
      default: begin
        state_next = WAIT_FRAME;
      end
    endcase
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// tb_cam_capture_rgb444
// Directed, self-checking bench for cam_capture_rgb444. Inputs change just
// after the falling edge and outputs are sampled on the falling edge.
module tb_cam_capture_rgb444;

  localparam int AW   = 15;
  localparam int DW   = 12;
  localparam int NPIX = 160 * 120;

  logic          pclk;
  logic          reset_n;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          overflow;

  int n_checks;
  int n_fail;
  int wr_count;
  int exp_addr;
  logic track_addr;

  typedef struct {
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [11:0] exp_px;
  } pix_vec_t;

  pix_vec_t vecs[6];

  cam_capture_rgb444 #(
    .AW    (AW),
    .DW    (DW),
    .IMG_W (160),
    .IMG_H (120)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wait for the next sampling point and log any write seen there.
  task automatic tick();
    @(negedge pclk);
    if (px_wr === 1'b1) begin
      wr_count++;
      if (track_addr) begin
        checkOutput("addr_seq", 32'(mem_px_addr), 32'(exp_addr));
        exp_addr++;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
    vsync   = v;
    href    = h;
    px_data = d;
    tick();
  endtask

  task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2);
    applyStimulus(1'b0, 1'b1, b1);
    applyStimulus(1'b0, 1'b1, b2);
  endtask

  task automatic frame_start();
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("frame_done_single", 32'(frame_done), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    wr_count   = 0;
    exp_addr   = 0;
    track_addr = 1'b0;
    reset_n    = 1'b0;
    vsync      = 1'b0;
    href       = 1'b0;
    px_data    = 8'h00;

    vecs[0] = '{b1: 8'hF8, b2: 8'h00, exp_px: 12'hF00};
    vecs[1] = '{b1: 8'h07, b2: 8'hE0, exp_px: 12'h0F0};
    vecs[2] = '{b1: 8'h00, b2: 8'h1F, exp_px: 12'h00F};
    vecs[3] = '{b1: 8'hFF, b2: 8'hFF, exp_px: 12'hFFF};
    vecs[4] = '{b1: 8'hA5, b2: 8'h5A, exp_px: 12'hAAD};
    vecs[5] = '{b1: 8'h12, b2: 8'h34, exp_px: 12'h14A};

    // Reset state.
    repeat (3) tick();
    checkOutput("rst_addr", 32'(mem_px_addr), 32'd0);
    checkOutput("rst_data", 32'(mem_px_data), 32'd0);
    checkOutput("rst_wr", 32'(px_wr), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    // Frame start and first pixel.
    frame_start();
    applyStimulus(1'b0, 1'b1, 8'hF8);
    checkOutput("first_wr_early", 32'(px_wr), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("first_wr", 32'(px_wr), 32'd1);
    checkOutput("first_addr", 32'(mem_px_addr), 32'd0);
    checkOutput("first_data", 32'(mem_px_data), 32'hF00);

    // Colour packing table, back-to-back pixels.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].b1);
      checkOutput("pack_wr_gap", 32'(px_wr), 32'd0);
      applyStimulus(1'b0, 1'b1, vecs[i].b2);
      checkOutput("pack_wr", 32'(px_wr), 32'd1);
      checkOutput("pack_addr", 32'(mem_px_addr), 32'(i + 1));
      checkOutput("pack_data", 32'(mem_px_data), 32'(vecs[i].exp_px));
    end

    // Odd byte line: 5th byte dropped, next line continues at addr 2.
    frame_end();
    frame_start();
    wr_count = 0;
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b1, 8'h33);
    applyStimulus(1'b0, 1'b1, 8'h44);
    applyStimulus(1'b0, 1'b1, 8'h55);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("odd_wr_count", 32'(wr_count), 32'd2);
    send_pixel(8'hF8, 8'h00);
    checkOutput("odd_next_wr", 32'(px_wr), 32'd1);
    checkOutput("odd_next_addr", 32'(mem_px_addr), 32'd2);
    checkOutput("odd_next_data", 32'(mem_px_data), 32'hF00);

    // Mid-line vsync with href high: frame ends, byte ignored, restart at 0.
    applyStimulus(1'b0, 1'b1, 8'hAA);
    applyStimulus(1'b1, 1'b1, 8'hBB);
    checkOutput("midv_done", 32'(frame_done), 32'd1);
    checkOutput("midv_nowr", 32'(px_wr), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("midv_done_off", 32'(frame_done), 32'd0);
    send_pixel(8'h07, 8'hE0);
    checkOutput("midv_wr", 32'(px_wr), 32'd1);
    checkOutput("midv_addr", 32'(mem_px_addr), 32'd0);
    checkOutput("midv_data", 32'(mem_px_data), 32'h0F0);

    // Full frame with line gaps.
    frame_end();
    frame_start();
    wr_count   = 0;
    exp_addr   = 0;
    track_addr = 1'b1;
    for (int line = 0; line < 120; line++) begin
      for (int p = 0; p < 160; p++) begin
        send_pixel(8'(p), 8'(line));
      end
      repeat (10) applyStimulus(1'b0, 1'b0, 8'h00);
    end
    track_addr = 1'b0;
    checkOutput("full_wr_count", 32'(wr_count), 32'(NPIX));
    frame_end();
    checkOutput("full_ovf", 32'(overflow), 32'd0);

    // Overflow: NPIX+1 pixels in one frame.
    frame_start();
    wr_count = 0;
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(8'hF8, 8'h00);
    end
    checkOutput("ovf_before", 32'(overflow), 32'd0);
    send_pixel(8'hFF, 8'hFF);
    checkOutput("ovf_last_nowr", 32'(px_wr), 32'd0);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_addr", 32'(mem_px_addr), 32'(NPIX));
    checkOutput("ovf_wr_count", 32'(wr_count), 32'(NPIX));
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("ovf_addr_hold", 32'(mem_px_addr), 32'(NPIX));
    frame_end();
    frame_start();
    send_pixel(8'h00, 8'h1F);
    checkOutput("ovf_next_addr", 32'(mem_px_addr), 32'd0);
    checkOutput("ovf_next_data", 32'(mem_px_data), 32'h00F);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset between byte1 and byte2.
    applyStimulus(1'b0, 1'b1, 8'h12);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_addr", 32'(mem_px_addr), 32'd0);
    checkOutput("arst_data", 32'(mem_px_data), 32'd0);
    checkOutput("arst_wr", 32'(px_wr), 32'd0);
    checkOutput("arst_ovf", 32'(overflow), 32'd0);
    checkOutput("arst_done", 32'(frame_done), 32'd0);
    tick();
    tick();
    reset_n  = 1'b1;
    wr_count = 0;
    repeat (6) applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("arst_no_wr", 32'(wr_count), 32'd0);
    frame_start();
    send_pixel(8'hA5, 8'h5A);
    checkOutput("arst_resume_wr", 32'(px_wr), 32'd1);
    checkOutput("arst_resume_addr", 32'(mem_px_addr), 32'd0);
    checkOutput("arst_resume_data", 32'(mem_px_data), 32'hAAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_capture_rgb444.md
Name: cam_capture_rgb444

Overview:
- Upstream stage of the dual-port frame buffer.
- Samples the OV7670-style camera bus (vsync, href, 8-bit data, RGB565 sent as two bytes per pixel) and packs each pixel to RGB444.
- Drives the buffer write port with address, data and write enable.
- Runs entirely in the camera pixel-clock domain; the buffer's clk_w is tied to the same pclk.

Parameters:
- AW, 15: buffer address width in bits.
- DW, 12: pixel width in bits; fixed RGB444, any other value is unsupported.
- IMG_W, 160: active pixels per line.
- IMG_H, 120: active lines per frame.
- NPIX (localparam), IMG_W*IMG_H = 19200: must be < 2**AW. The last buffer address (2**AW-1) is never written.

Ports:
- pclk  in  1  camera pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  frame sync; high = vertical blanking / frame boundary.
- href  in  1  line valid; high while pixel bytes are on px_data.
- px_data  in  8  camera byte bus.
- mem_px_addr  out  AW  buffer write address (to addr_in).
- mem_px_data  out  DW  RGB444 pixel {R[3:0],G[3:0],B[3:0]} (to data_in).
- px_wr  out  1  write strobe (to regwrite), one pclk per pixel.
- frame_done  out  1  one-cycle pulse when a frame ends.
- overflow  out  1  sticky; set when a pixel arrives with addr already at NPIX.

Behaviour:
- Reset (reset_n=0, async): state=WAIT_FRAME, mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overflow=0.
- All outputs are registered. No combinational path from input to output.
- FSM states:
  - WAIT_FRAME: ignore href/data. On vsync 1->0 (registered vsync_q=1, vsync=0): addr<=0, go BYTE1.
  - BYTE1: if href=1, latch px_data into hi_byte and go BYTE2. If href=0, stay.
  - BYTE2: if href=1, form pixel, request write, go BYTE1. If href=0 (odd byte count, line ended mid-pixel), discard hi_byte, no write, go BYTE1.
- Pixel packing (byte1 = R5G3hi, byte2 = G3lo B5):
  - R = hi[7:4]
  - G = {hi[2:0], px_data[7]}
  - B = px_data[4:1]
- Write timing:
  - px_wr=1 in the cycle after the second byte is sampled.
  - mem_px_addr shows the address being written during that cycle.
  - The address increments on the following edge, so consecutive pixels give consecutive addresses.
  - Back-to-back pixels produce a px_wr pulse every 2 pclk.
- Boundary at addr == NPIX:
  - Further pixels are not written (px_wr stays 0).
  - overflow<=1 and stays set until reset.
  - addr holds at NPIX; no wrap-around.
- Frame end: vsync 0->1 while in BYTE1 or BYTE2 gives frame_done=1 for exactly one cycle, then WAIT_FRAME. A pending hi_byte is discarded.
- Mid-frame vsync pulse: handled as a frame end. The next frame restarts at addr 0.
- vsync=1 and href=1 in the same cycle: vsync wins; the byte is ignored.
- Reset mid-pixel: discards all state. No spurious px_wr after release; capture resumes only after the next vsync 1->0.
- Short frame (fewer than NPIX pixels): frame_done still pulses. Unwritten buffer locations keep their old contents.

Decomposition:
- Shared package cam_pkg:
  - IMG_W, IMG_H, NPIX.
  - Capture state encoding (WAIT_FRAME=2'd0, BYTE1=2'd1, BYTE2=2'd2).
  - RGB565->RGB444 bit-slice constants.
- Sub-module: rgb565_to_rgb444, purely combinational, 16 bits in, 12 bits out. Also reused by the VGA test pattern path.
- FSM, counter and edge detect stay in cam_capture_rgb444.

Test Plan:
- Frame start and first pixel: reset_n low 3 cycles; vsync 1->0; href=1 with bytes 8'hF8, 8'h00. Expect px_wr=1 exactly 1 cycle after the second byte, mem_px_addr=0, mem_px_data=12'hF00.
- Colour packing: bytes 8'h07,8'hE0 give 12'h0F0; 8'h00,8'h1F give 12'h00F; 8'hFF,8'hFF give 12'hFFF.
- Full frame: 120 lines of 320 bytes with 10-cycle href-low gaps. Expect 19200 px_wr pulses, addresses 0..19199 in order. Then vsync rise gives a single-cycle frame_done and overflow=0.
- Odd byte line: href high for 5 bytes. Expect 2 writes; the 5th byte is dropped; the next line's first pixel uses addr+2 with correct packing.
- Overflow: send 19201 pixels in one frame. Expect the last pixel is not written, overflow=1 sticky, mem_px_addr=19200. The next frame's first write goes to addr 0, and overflow stays 1.
- Reset/vsync mid-operation: assert reset_n=0 between byte1 and byte2. Expect outputs at reset values immediately (async) and no px_wr until after the next vsync 1->0. Separately, a vsync pulse mid-line gives a frame_done pulse and a restart at addr 0.
